fir_tap_sequencer: RTL

FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

---
 rtl/fir_tap_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/fir_tap_sequencer.sv
// Delay line and tap sequencer for a 4-lane time-multiplexed FIR.
// Each accepted strobe shifts the line and runs one TPL-cycle MAC pass.
module fir_tap_sequencer #(
   parameter  int DW  = 16,
   parameter  int TPL = 10,
   localparam int AW  = (TPL > 1) ? $clog2(TPL) : 1
) (
   input  logic          iClk_12M,
   input  logic          iRsn,
   input  logic          iEnSample_600k,
   input  logic [DW-1:0] iFirIn,
   output logic [DW-1:0] oTap1,
   output logic [DW-1:0] oTap2,
   output logic [DW-1:0] oTap3,
   output logic [DW-1:0] oTap4,
   output logic [AW-1:0] oCoeffAddr,
   output logic          oEnMac,
   output logic          oMacClr,
   output logic          oEnDelay,
   output logic          oOverrun
);

   localparam int NT = 4 * TPL;
   localparam int IW = $clog2(NT);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [AW-1:0] addr;
   logic          en_delay;
   logic          overrun;
   logic [DW-1:0] d [NT];

   logic run;
   logic last;
   logic accept;

   assign run    = (state == RUN);
   assign last   = (addr == AW'(TPL - 1));
   // A strobe landing during a pass (including its last cycle) is dropped
   assign accept = iEnSample_600k && !run;

   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         state    <= IDLE;
         addr     <= '0;
         en_delay <= 1'b0;
         overrun  <= 1'b0;
         for (int i = 0; i < NT; i++) d[i] <= '0;
      end else begin
         if (accept) begin
            d[0] <= iFirIn;
            for (int i = 1; i < NT; i++) d[i] <= d[i-1];
         end
         case (state)
            IDLE, DONE: begin
               if (iEnSample_600k) begin
                  state <= RUN;
                  addr  <= '0;
               end
            end
            RUN: begin
               if (iEnSample_600k) overrun <= 1'b1;
               if (last) begin
                  state    <= DONE;
                  en_delay <= 1'b1;
               end else begin
                  addr <= addr + AW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [DW-1:0] tap [4];

   for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [IW-1:0] idx;
      assign idx    = IW'(k * TPL) + IW'(addr);
      assign tap[k] = run ? d[idx] : '0;
   end

   assign oTap1      = tap[0];
   assign oTap2      = tap[1];
   assign oTap3      = tap[2];
   assign oTap4      = tap[3];
   assign oCoeffAddr = run ? addr : '0;
   assign oEnMac     = run;
   assign oMacClr    = run && (addr == '0);
   assign oEnDelay   = en_delay;
   assign oOverrun   = overrun;

endmodule
